// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
//   Instruction-fetch front end. Owns the fetch PC, issues in-order requests
//   to a variable-latency instruction memory, buffers returned words in a
//   DEPTH-entry first-word-fall-through queue and hands {inst, pc+4} to the
//   decode stage through a valid/ready handshake. A redirect (taken branch)
//   flushes the queue and discards every response still in flight.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   imem_req_valid/ready/addr       fetch request channel (word-aligned address)
//   imem_resp_valid/data            in-order response, one per accepted request
//   redirect, redirect_pc           taken-branch pulse and its target
//   out_valid/ready                 handshake towards IF/ID
//   out_inst, out_pc_plus4          head instruction and its address + 4
// ---------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc_plus4
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              started_reg;
    logic [31:0]       fetch_pc_reg;
    logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0]  q_count_reg;
    logic [PTR_W-1:0]  q_head_reg, q_tail_reg;
    logic [PTR_W-1:0]  tag_head_reg, tag_tail_reg;
    logic [31:0]       last_inst_reg, last_pc4_reg;

    logic [31:0]       q_inst_mem [DEPTH];
    logic [31:0]       q_pc4_mem  [DEPTH];
    logic [31:0]       tag_mem    [DEPTH];

    logic              q_empty, q_full;
    logic [CNT_W:0]    credit_used;
    logic              credit_ok;
    logic              req_fire, resp_keep, pop;
    logic              resp_counted;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign q_empty     = (q_count_reg == '0);
    assign q_full      = (q_count_reg == CNT_W'(DEPTH));
    // Every accepted request owns a queue slot until it is consumed, so the
    // queue can never overflow when a kept response is pushed.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, q_count_reg};
    assign credit_ok   = (credit_used < (CNT_W + 1)'(DEPTH));

    // started_reg keeps the request line low until the first edge after reset.
    assign imem_req_valid = started_reg && credit_ok && (drop_cnt_reg == '0) && !redirect;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses for pre-redirect requests are dropped until drop_cnt drains;
    // the word landing in the redirect cycle itself is dropped as well.
    assign resp_keep    = imem_resp_valid && (drop_cnt_reg == '0) && !redirect;
    assign resp_counted = imem_resp_valid && (outstanding_reg != '0);

    assign out_valid    = !q_empty && !redirect;
    assign pop          = out_valid && out_ready;
    assign out_inst     = q_empty ? last_inst_reg : q_inst_mem[q_head_reg];
    assign out_pc_plus4 = q_empty ? last_pc4_reg  : q_pc4_mem[q_head_reg];

    always_comb begin
        outstanding_next = outstanding_reg;
        if (req_fire) begin
            outstanding_next = outstanding_next + CNT_W'(1);
        end
        if (resp_counted) begin
            outstanding_next = outstanding_next - CNT_W'(1);
        end
    end

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (redirect) begin
            drop_cnt_next = outstanding_reg - CNT_W'(resp_counted);
        end else if (imem_resp_valid && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_reg     <= 1'b0;
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            q_count_reg     <= '0;
            q_head_reg      <= '0;
            q_tail_reg      <= '0;
            tag_head_reg    <= '0;
            tag_tail_reg    <= '0;
            last_inst_reg   <= '0;
            last_pc4_reg    <= '0;
        end else begin
            started_reg     <= 1'b1;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            if (redirect) begin
                fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
                q_count_reg  <= '0;
                q_head_reg   <= '0;
                q_tail_reg   <= '0;
                tag_head_reg <= '0;
                tag_tail_reg <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                    tag_tail_reg <= tag_tail_reg + PTR_W'(1);
                end
                if (resp_keep) begin
                    tag_head_reg <= tag_head_reg + PTR_W'(1);
                    q_tail_reg   <= q_tail_reg + PTR_W'(1);
                end
                if (pop) begin
                    q_head_reg    <= q_head_reg + PTR_W'(1);
                    last_inst_reg <= out_inst;
                    last_pc4_reg  <= out_pc_plus4;
                end
                q_count_reg <= q_count_reg + CNT_W'(resp_keep) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: nothing is read until the matching pointer
    // or count says the entry has been written.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_tail_reg] <= fetch_pc_reg;
        end
        if (resp_keep) begin
            q_inst_mem[q_tail_reg] <= imem_resp_data;
            q_pc4_mem[q_tail_reg]  <= tag_mem[tag_head_reg] + 32'd4;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(resp_keep && q_full));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc_plus4;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc_plus4    (out_pc_plus4)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] issued_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0;
    int          lat = 1;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.inst = inst_of(pc);
        e.pc4  = pc + 32'd4;
        exp_q.push_back(e);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic check_issued(input string name, input int idx, input logic [31:0] want);
        if (idx < issued_q.size()) begin
            check32(name, issued_q[idx], want);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s got no request want %h", name, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic pop_one;
        int n = 0;
        while (!out_valid && n < 50) begin
            tick;
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout got out_valid=0 want 1");
        end else begin
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
        end
    endtask

    // Instruction memory model: fixed latency, in-order, one response per cycle.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset || pend_addr.size() == 0 || pend_due[0] > cyc) begin
                imem_resp_valid = 1'b0;
            end else begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = inst_of(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                issued_q.push_back(imem_req_addr);
            end
        end
    end

    // Scoreboard monitor: compares every accepted output against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop got pc4=%h inst=%h want nothing", out_pc_plus4, out_inst);
                end else begin
                    e = exp_q.pop_front();
                    if (out_inst !== e.inst || out_pc_plus4 !== e.pc4) begin
                        errors++;
                        $display("FAIL pop got pc4=%h inst=%h want pc4=%h inst=%h",
                                 out_pc_plus4, out_inst, e.pc4, e.inst);
                    end else begin
                        $display("pop pc4=%h inst=%h ok", out_pc_plus4, out_inst);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int n;

        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;

        // Reset state and start-up latency with a zero-wait memory.
        repeat (3) tick;
        check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check32("rst_out_inst", out_inst, 32'h0);
        check32("rst_out_pc4", out_pc_plus4, 32'h0);
        check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        expect_pc(32'h0);
        expect_pc(32'h4);
        reset = 1'b0;
        #1;
        check32("req_before_first_edge", {31'b0, imem_req_valid}, 32'd0);
        tick;
        check32("req1_valid", {31'b0, imem_req_valid}, 32'd1);
        check32("req1_addr", imem_req_addr, 32'h0);
        tick;
        check32("req2_addr", imem_req_addr, 32'h4);
        tick;
        check32("first_out_valid", {31'b0, out_valid}, 32'd1);
        check32("first_pc4", out_pc_plus4, 32'h4);
        tick;
        check32("second_pc4", out_pc_plus4, 32'h8);
        tick;
        check32("third_pc4", out_pc_plus4, 32'hC);
        out_ready = 1'b0;

        // Decode stall: issue stops at the credit limit, head holds.
        for (int i = 0; i < 10; i++) begin
            tick;
            check32("stall_head_pc4", out_pc_plus4, 32'hC);
        end
        check32("stall_head_inst", out_inst, inst_of(32'h8));
        check32("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check32("stall_issued_count", issued_q.size(), 32'd6);
        m = issued_q.size();
        for (int i = 0; i < 6; i++) begin
            expect_pc(32'h8 + 32'(4 * i));
            pop_one();
        end
        check_issued("restart_addr", m, 32'h18);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        repeat (12) tick;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick;
        redirect = 1'b0;
        n = 0;
        while (pend_addr.size() < 2 && n < 20) begin
            tick;
            n++;
        end
        check32("two_outstanding", pend_addr.size(), 32'd2);
        check32("no_resp_at_redirect", {31'b0, imem_resp_valid}, 32'd0);
        m = issued_q.size();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check32("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check32("redir_out_valid", {31'b0, out_valid}, 32'd0);
        tick;
        redirect = 1'b0;
        repeat (14) tick;
        check_issued("redir_first_addr", m, 32'h40);
        check32("redir_head_pc4", out_pc_plus4, 32'h44);
        expect_pc(32'h40);
        pop_one();
        expect_pc(32'h44);
        pop_one();

        // Redirect colliding with a response and an output handshake.
        n = 0;
        while (!(imem_resp_valid && out_valid) && n < 30) begin
            tick;
            n++;
        end
        check32("collision_found", {31'b0, imem_resp_valid && out_valid}, 32'd1);
        m = issued_q.size();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        out_ready = 1'b1;
        #1;
        check32("coll_out_valid", {31'b0, out_valid}, 32'd0);
        check32("coll_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick;
        redirect = 1'b0;
        out_ready = 1'b0;
        repeat (14) tick;
        check_issued("coll_first_addr", m, 32'h200);
        check32("coll_head_inst", out_inst, inst_of(32'h200));
        expect_pc(32'h200);
        pop_one();

        // Target near the top of memory: unaligned bits dropped, PC wraps.
        lat = 1;
        repeat (10) tick;
        m = issued_q.size();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick;
        redirect = 1'b0;
        repeat (10) tick;
        check_issued("wrap_addr0", m, 32'hFFFF_FFFC);
        check_issued("wrap_addr1", m + 1, 32'h0);
        check32("wrap_head_pc4", out_pc_plus4, 32'h0);
        expect_pc(32'hFFFF_FFFC);
        pop_one();
        expect_pc(32'h0);
        pop_one();

        // Reset in the middle of a stream with three queued entries.
        repeat (6) tick;
        expect_pc(32'h4);
        pop_one();
        reset = 1'b1;
        #1;
        check32("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check32("midrst_out_pc4", out_pc_plus4, 32'h0);
        check32("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        check32("midrst_req_after_release", {31'b0, imem_req_valid}, 32'd0);
        m = issued_q.size();
        repeat (5) tick;
        check_issued("midrst_restart_addr", m, 32'h0);
        expect_pc(32'h0);
        pop_one();

        repeat (3) tick;
        check32("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
